// File: rtl/rp2040_spi_master_if.sv
// Request/response bundle between control logic and the SPI initiator.
// master = requestor side, slave = SPI initiator side.
interface rp2040_spi_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output busy
  );
endinterface

// File: rtl/rp2040_spi_master.sv
// Mode-0 SPI initiator: 8-bit command byte then 32-bit data word,
// returning the data-phase MISO bits as read data.
module rp2040_spi_master #(
  parameter int CLK_DIV     = 4,
  parameter int CS_HOLD_CYC = 2,
  parameter int CS_GAP_CYC  = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  rp2040_spi_master_if.slave bus,
  output logic               spi_sclk,
  output logic               spi_mosi,
  output logic               spi_cs_n,
  input  logic               spi_miso
);

  localparam int         FW       = 8 + DATA_WIDTH;
  localparam logic [5:0] LAST_BIT = 6'(FW - 1);
  localparam logic [5:0] FIRST_RX = 6'd8;
  localparam logic [7:0] DIV_END  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_END = 8'(CS_HOLD_CYC - 1);
  localparam logic [7:0] GAP_END  = 8'(CS_GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            div_q, div_d;
  logic [5:0]            bit_q, bit_d;
  logic [7:0]            cyc_q, cyc_d;
  logic [FW-1:0]         tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  rsp_q, rsp_d;
  logic                  miso_s1_q, miso_s2_q;
  logic [DATA_WIDTH-1:0] wdata_sel;

  // two-flop synchronizer for the asynchronous MISO pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  // frame sequencing: accept, shift 40 bits, hold cs, enforce gap
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    cyc_d     = cyc_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    rsp_d     = 1'b0;
    wdata_sel = bus.req_write ? bus.req_wdata
                              : {DATA_WIDTH{1'b0}};
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          tx_d    = {bus.req_write, bus.req_addr,
                     wdata_sel};
          mosi_d  = bus.req_write;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_END) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q >= FIRST_RX) begin
              rx_d = {rx_q[DATA_WIDTH-2:0], miso_s2_q};
            end
            if (bit_q == LAST_BIT) begin
              mosi_d  = 1'b0;
              cyc_d   = '0;
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + 6'd1;
              tx_d   = {tx_q[FW-2:0], 1'b0};
              mosi_d = tx_q[FW-2];
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HOLD: begin
        if (cyc_q == HOLD_END) begin
          cs_n_d  = 1'b1;
          rsp_d   = 1'b1;
          rdata_d = rx_q;
          cyc_d   = '0;
          state_d = GAP;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      GAP: begin
        if (cyc_q == GAP_END) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = mosi_q;
  assign spi_cs_n      = cs_n_q;

endmodule

// File: tb/tb_rp2040_spi_master.sv
// Bench for rp2040_spi_master: default config plus
// CLK_DIV=2 and CLK_DIV=255 instances sharing one request stream.
module tb_rp2040_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail = 0;

  logic        tb_valid = 1'b0;
  logic        tb_write = 1'b0;
  logic [6:0]  tb_addr = 7'h0;
  logic [31:0] tb_wdata = 32'h0;
  logic        sweep_en = 1'b0;
  logic [31:0] slave_word = 32'h0;

  wire        m_ready [3];
  wire        m_busy [3];
  wire        m_rsp [3];
  wire        m_sclk [3];
  wire        m_mosi [3];
  wire        m_cs [3];
  wire [31:0] m_rdata [3];
  wire [39:0] m_frame [3];
  wire [31:0] m_edges [3];
  wire [31:0] m_low [3];
  wire [31:0] m_hi [3];
  wire [31:0] m_viol [3];
  wire [31:0] m_rcnt [3];
  wire [31:0] m_rlow [3];
  wire [31:0] m_blow [3];
  wire [31:0] m_falls [3];

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 255;
  endfunction

  function automatic int hold_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int D = (g == 0) ? 4 : (g == 1) ? 2 : 255;
    localparam int H = (g == 0) ? 2 : 1;

    rp2040_spi_master_if bus ();
    logic miso = 1'b0;
    logic sclk, mosi, cs_n;

    assign bus.req_valid = (g == 0) ? tb_valid
                                    : (tb_valid & sweep_en);
    assign bus.req_write = tb_write;
    assign bus.req_addr  = tb_addr;
    assign bus.req_wdata = tb_wdata;

    rp2040_spi_master #(
      .CLK_DIV    (D),
      .CS_HOLD_CYC(H),
      .CS_GAP_CYC (4),
      .DATA_WIDTH (32)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .spi_sclk(sclk),
      .spi_mosi(mosi),
      .spi_cs_n(cs_n),
      .spi_miso(miso)
    );

    // slave: junk command-phase bits, then slave_word MSB first,
    // next bit presented after each SCLK fall
    logic [39:0] sl_bits = '0;
    int          sl_k = 0;
    bit          in_frame = 0;
    always @(negedge cs_n or posedge cs_n or negedge sclk) begin
      if (cs_n) begin
        in_frame = 0;
      end else if (!in_frame) begin
        in_frame = 1;
        sl_bits = {8'hA5, slave_word};
        sl_k = 0;
      end else begin
        sl_k++;
      end
      #1 miso = (sl_k < 40) ? sl_bits[39 - sl_k] : 1'b0;
    end

    // protocol monitor sampled mid-cycle
    int edges = 0, low = 0, last_low = 0, hi = 0, last_hi = 0;
    int viol = 0, rcnt = 0, rlow = 0, blow = 0, falls = 0;
    int run = 0;
    logic [39:0] frame = '0;
    logic [31:0] rdat = '0;
    logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
    always @(negedge clk) begin
      if (!rst_n) begin
        p_cs = 1'b1;
        p_sclk = 1'b0;
        p_mosi = 1'b0;
      end else begin
        if (p_cs && !cs_n) begin
          edges = 0;
          frame = '0;
          low = 0;
          run = 0;
          rlow = 0;
          blow = 0;
          falls++;
          last_hi = hi;
        end
        if (cs_n) hi++;
        else hi = 0;
        if (!cs_n) low++;
        if (!p_cs && cs_n) begin
          last_low = low;
          if (run != H) viol++;
        end
        if (!bus.req_ready) rlow++;
        if (bus.busy) blow++;
        if (cs_n && (sclk || mosi)) viol++;
        if ((cs_n != p_cs) && (sclk != p_sclk)) viol++;
        if (!cs_n) begin
          if (sclk != p_sclk) begin
            if (run != D) viol++;
            run = 1;
            if (sclk) begin
              edges++;
              frame = {frame[38:0], mosi};
            end
          end else begin
            run++;
          end
          if (!p_cs && (mosi != p_mosi) && !(p_sclk && !sclk))
            viol++;
        end
        if (bus.rsp_valid) begin
          rcnt++;
          rdat = bus.rsp_rdata;
          if (!(cs_n && !p_cs)) viol++;
        end
        p_cs = cs_n;
        p_sclk = sclk;
        p_mosi = mosi;
      end
    end

    assign m_ready[g] = bus.req_ready;
    assign m_busy[g]  = bus.busy;
    assign m_rsp[g]   = bus.rsp_valid;
    assign m_sclk[g]  = sclk;
    assign m_mosi[g]  = mosi;
    assign m_cs[g]    = cs_n;
    assign m_rdata[g] = bus.rsp_rdata;
    assign m_frame[g] = frame;
    assign m_edges[g] = edges;
    assign m_low[g]   = last_low;
    assign m_hi[g]    = last_hi;
    assign m_viol[g]  = viol;
    assign m_rcnt[g]  = rcnt;
    assign m_rlow[g]  = rlow;
    assign m_blow[g]  = blow;
    assign m_falls[g] = falls;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one request through all active instances, checked against model
  task automatic send(input logic w, input logic [6:0] a,
                      input logic [31:0] d, input logic [31:0] sw,
                      input string tag);
    logic [39:0] ef;
    int r0 [3];
    int n, lim, top;
    bit done;
    ef = {w, a, w ? d : 32'h0};
    for (int i = 0; i < 3; i++) r0[i] = int'(m_rcnt[i]);
    slave_word = sw;
    @(posedge clk);
    #1;
    tb_valid = 1'b1;
    tb_write = w;
    tb_addr = a;
    tb_wdata = d;
    @(posedge clk);
    #1;
    tb_valid = 1'b0;
    tb_write = 1'($urandom);
    tb_addr = 7'($urandom);
    tb_wdata = $urandom;
    lim = sweep_en ? 21000 : 400;
    top = sweep_en ? 3 : 1;
    n = 0;
    done = 0;
    while (!done && n < lim) begin
      @(negedge clk);
      n++;
      done = 1;
      for (int i = 0; i < top; i++)
        if (!m_ready[i] || int'(m_rcnt[i]) == r0[i]) done = 0;
    end
    chk($sformatf("%s done", tag), 64'(done), 64'd1);
    for (int i = 0; i < top; i++) begin
      chk($sformatf("%s[%0d] mosi", tag, i),
          64'(m_frame[i]), 64'(ef));
      chk($sformatf("%s[%0d] edges", tag, i),
          64'(m_edges[i]), 64'd40);
      chk($sformatf("%s[%0d] cs_low", tag, i),
          64'(m_low[i]), 64'(80 * div_of(i) + hold_of(i)));
      chk($sformatf("%s[%0d] rdata", tag, i),
          64'(m_rdata[i]), 64'(sw));
      chk($sformatf("%s[%0d] rsp_cnt", tag, i),
          64'(int'(m_rcnt[i]) - r0[i]), 64'd1);
      chk($sformatf("%s[%0d] proto", tag, i),
          64'(m_viol[i]), 64'd0);
    end
    chk($sformatf("%s ready_low", tag), 64'(m_rlow[0]), 64'd326);
    chk($sformatf("%s busy_len", tag), 64'(m_blow[0]), 64'd326);
  endtask

  initial begin
    int r0, f0, n;
    logic [31:0] wa, wb;

    #2 rst_n = 1'b0;
    #2;
    chk("rst ready", 64'(m_ready[0]), 64'd1);
    chk("rst rsp", 64'(m_rsp[0]), 64'd0);
    chk("rst rdata", 64'(m_rdata[0]), 64'd0);
    chk("rst busy", 64'(m_busy[0]), 64'd0);
    chk("rst sclk", 64'(m_sclk[0]), 64'd0);
    chk("rst mosi", 64'(m_mosi[0]), 64'd0);
    chk("rst cs_n", 64'(m_cs[0]), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    send(1'b1, 7'h00, 32'h4000_0000, $urandom, "wr");
    send(1'b0, 7'h10, 32'h1234_5678, 32'h0000_A5C3, "rd");
    for (int k = 0; k < 6; k++)
      send(1'($urandom), 7'($urandom), $urandom, $urandom, "rand");

    // back-to-back with req_valid held through the gap
    wa = $urandom;
    wb = $urandom;
    r0 = int'(m_rcnt[0]);
    f0 = int'(m_falls[0]);
    slave_word = wa;
    @(posedge clk);
    #1;
    tb_valid = 1'b1;
    tb_write = 1'b1;
    tb_addr = 7'h55;
    tb_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    tb_write = 1'b0;
    tb_addr = 7'h21;
    tb_wdata = $urandom;
    slave_word = wb;
    n = 0;
    while (int'(m_rcnt[0]) == r0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b rsp1 seen", 64'(n < 400), 64'd1);
    chk("b2b frame1", 64'(m_frame[0]), {24'h0, 1'b1, 7'h55, 32'hCAFE_F00D});
    chk("b2b rdata1", 64'(m_rdata[0]), 64'(wa));
    n = 0;
    while (int'(m_falls[0]) == f0 + 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b second cs fall", 64'(m_falls[0]), 64'(f0 + 2));
    chk("b2b cs high len", 64'(m_hi[0]), 64'd5);
    @(posedge clk);
    #1 tb_valid = 1'b0;
    n = 0;
    while (int'(m_rcnt[0]) == r0 + 1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b frame2", 64'(m_frame[0]), {24'h0, 1'b0, 7'h21, 32'h0});
    chk("b2b rdata2", 64'(m_rdata[0]), 64'(wb));
    repeat (8) @(negedge clk);
    chk("b2b frames", 64'(m_falls[0]), 64'(f0 + 2));
    chk("b2b ready_low", 64'(m_rlow[0]), 64'd326);

    // requests offered while busy are ignored
    r0 = int'(m_rcnt[0]);
    f0 = int'(m_falls[0]);
    slave_word = $urandom;
    @(posedge clk);
    #1;
    tb_valid = 1'b1;
    tb_write = 1'b1;
    tb_addr = 7'h2A;
    tb_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 tb_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    tb_valid = 1'b1;
    tb_write = 1'b0;
    tb_addr = 7'h7F;
    chk("hs ready mid", 64'(m_ready[0]), 64'd0);
    @(posedge clk);
    #1 tb_valid = 1'b0;
    n = 0;
    while (int'(m_rcnt[0]) == r0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("hs rsp seen", 64'(n < 400), 64'd1);
    @(posedge clk);
    #1 tb_valid = 1'b1;
    chk("hs ready gap", 64'(m_ready[0]), 64'd0);
    @(posedge clk);
    #1 tb_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("hs frames", 64'(m_falls[0]), 64'(f0 + 1));
    chk("hs rsp_cnt", 64'(m_rcnt[0]), 64'(r0 + 1));
    chk("hs ready", 64'(m_ready[0]), 64'd1);
    chk("hs frame", 64'(m_frame[0]), {24'h0, 1'b1, 7'h2A, 32'hDEAD_BEEF});
    chk("hs ready_low", 64'(m_rlow[0]), 64'd326);

    // reset during bit 20
    r0 = int'(m_rcnt[0]);
    @(posedge clk);
    #1;
    tb_valid = 1'b1;
    tb_write = 1'b1;
    tb_addr = 7'h3C;
    tb_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 tb_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (int'(m_edges[0]) < 21 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid reach bit20", 64'(n < 400), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid cs_n", 64'(m_cs[0]), 64'd1);
    chk("rstmid sclk", 64'(m_sclk[0]), 64'd0);
    chk("rstmid mosi", 64'(m_mosi[0]), 64'd0);
    chk("rstmid busy", 64'(m_busy[0]), 64'd0);
    chk("rstmid rsp", 64'(m_rsp[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("rstmid no rsp", 64'(m_rcnt[0]), 64'(r0));
    chk("rstmid ready", 64'(m_ready[0]), 64'd1);
    chk("rstmid rdata", 64'(m_rdata[0]), 64'd0);
    chk("rstmid cs idle", 64'(m_cs[0]), 64'd1);

    // parameter sweep: CLK_DIV 2 and 255 with CS_HOLD_CYC 1
    sweep_en = 1'b1;
    send(1'b1, 7'($urandom), $urandom, $urandom, "sw_wr");
    send(1'b0, 7'($urandom), $urandom, $urandom, "sw_rd");
    sweep_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
